// File: rtl/pipelined_adder_nbit_if.sv
// Operand/result bundle for the pipelined add/subtract unit.
// Latency: none, wires only.
// Backpressure: ready_o flows back to the producer and ready_i to the unit.
interface pipelined_adder_nbit_if #(
    parameter int WIDTH = 16
);
    // Operand side
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
    logic             sub_i;

    // Result side
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             ovf_o;

    // The arithmetic unit itself
    modport slave (
        input  valid_i, a_i, b_i, cin_i, sub_i, ready_i,
        output ready_o, valid_o, sum_o, cout_o, ovf_o
    );

    // The surrounding datapath: operand producer plus result consumer
    modport master (
        output valid_i, a_i, b_i, cin_i, sub_i, ready_i,
        input  ready_o, valid_o, sum_o, cout_o, ovf_o
    );
endinterface

// File: rtl/pipelined_adder_nbit.sv
// Pipelined WIDTH-bit add/subtract; the carry ripples one WIDTH/STAGES-bit chunk per stage.
// Latency: STAGES cycles from acceptance to valid_o; one result per cycle.
// Backpressure: global stall; the whole pipe holds while valid_o=1 and ready_i=0.
module pipelined_adder_nbit #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    pipelined_adder_nbit_if.slave  bus
);

    // WIDTH must divide evenly into STAGES chunks
    localparam int C   = WIDTH / STAGES;
    localparam int MSB = WIDTH - 1;

    // One pipeline slot. The operands travel in full so that the high chunks
    // are still available to later stages and the operand MSBs reach the
    // last stage for the overflow flag. bp is B already inverted for subtract.
    typedef struct packed {
        logic             vld;
        logic             carry;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] bp;
        logic [WIDTH-1:0] sum;
    } stage_t;

    stage_t     src   [STAGES];
    stage_t     stg_d [STAGES];
    stage_t     stg_q [STAGES];
    logic [C:0] chunk [STAGES];
    logic       ovf_d;
    logic       ovf_q;
    logic       advance;

    // The pipe moves as a single unit: bubbles are not squeezed out during a stall
    assign advance     = !stg_q[STAGES-1].vld || bus.ready_i;
    assign bus.ready_o = advance;

    // Input of each stage: the operand ports for stage 0, the previous register otherwise
    always_comb begin
        src[0].vld   = bus.valid_i && advance;
        src[0].carry = bus.sub_i ? 1'b1 : bus.cin_i;
        src[0].a     = bus.a_i;
        src[0].bp    = bus.sub_i ? ~bus.b_i : bus.b_i;
        src[0].sum   = '0;
        for (int k = 1; k < STAGES; k++) begin
            src[k] = stg_q[k-1];
        end
    end

    // Each stage adds its own chunk and hands the carry to the next stage
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            chunk[k] = {1'b0, src[k].a[k*C +: C]}
                     + {1'b0, src[k].bp[k*C +: C]}
                     + {{C{1'b0}}, src[k].carry};
            stg_d[k]               = src[k];
            stg_d[k].carry         = chunk[k][C];
            stg_d[k].sum[k*C +: C] = chunk[k][C-1:0];
        end
    end

    // Signed overflow: like-signed operands whose sum has the other sign
    assign ovf_d = (src[STAGES-1].a[MSB] == src[STAGES-1].bp[MSB])
                && (stg_d[STAGES-1].sum[MSB] != src[STAGES-1].a[MSB]);

    // Stage registers: cleared on reset, shift together on advance, hold otherwise
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < STAGES; k++) begin
                stg_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                stg_q[k] <= stg_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign bus.valid_o = stg_q[STAGES-1].vld;
    assign bus.sum_o   = stg_q[STAGES-1].sum;
    assign bus.cout_o  = stg_q[STAGES-1].carry;
    assign bus.ovf_o   = ovf_q;

endmodule

// File: doc/pipelined_adder_nbit.md
Name: pipelined_adder_nbit

Overview:
Parametrised pipelined add/subtract unit. It is the multi-bit successor of the 1-bit full adder. Operands of WIDTH bits are split into STAGES equal chunks, and the carry ripples chunk-by-chunk through registered stages, giving one result per cycle at STAGES-cycle latency. It sits in the datapath between operand producers and result consumers, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages; each stage adds WIDTH/STAGES bits; 1 <= STAGES <= WIDTH.

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
valid_i  input  1  operand transaction valid
ready_o  output  1  unit accepts transaction this cycle
a_i  input  WIDTH  operand A
b_i  input  WIDTH  operand B
cin_i  input  1  carry-in; ignored when sub_i=1
sub_i  input  1  0: A+B+cin_i; 1: A-B (A + ~B + 1)
valid_o  output  1  result valid
ready_i  input  1  consumer accepts result
sum_o  output  WIDTH  result
cout_o  output  1  carry-out of MSB; in subtract mode 1 = no borrow
ovf_o  output  1  two's-complement signed overflow

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous, active-low: rst_n_i=0 immediately clears all stage valid bits, so valid_o=0. sum_o, cout_o and ovf_o reset to 0. Data registers also clear.
- Chunk arithmetic: C = WIDTH/STAGES. Stage k (0..STAGES-1) adds bits [k*C+C-1 : k*C] of A and B', where B' = sub_i ? ~B : B. Carry into stage 0 is sub_i ? 1 : cin_i. Carry into stage k>0 is the registered carry from stage k-1.
- Operand skew: bits not yet consumed travel down the pipe in registers. Completed low chunks travel with them. After stage STAGES-1 the full WIDTH-bit sum is registered on sum_o.
- Flags: cout_o is the carry out of stage STAGES-1. ovf_o = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), evaluated in the last stage, so A[MSB] and B'[MSB] must be carried to it.
- Handshake (global stall):
  - advance = !valid_o || ready_i; ready_o = advance (combinational).
  - A transaction is accepted when valid_i && ready_o.
  - On advance, every stage register loads from its predecessor. Stage 0 valid loads valid_i && ready_o.
  - When advance=0, all registers, including outputs, hold; sum_o, cout_o and ovf_o must stay stable while valid_o=1 and ready_i=0.
- Latency and throughput: with ready_i held 1, a result appears on valid_o exactly STAGES cycles after acceptance. Throughput is 1 per cycle. Results keep acceptance order.
- Bubbles: bubbles are not compressed. An empty interior stage does not let upstream data advance while the output is stalled.
- Wrap-around: results are modulo 2^WIDTH. All-ones + 1 gives 0 with cout_o=1.
- Simultaneous events:
  - Output consumed and new input accepted in the same cycle is legal; the pipe shifts by one.
  - valid_i with ready_o=0: the transaction is not taken. The source must hold it.
- Reset mid-operation: all in-flight transactions are discarded. No partial result is emitted after rst_n_i deasserts; valid_o stays 0 until a new acceptance has travelled STAGES cycles.
- STAGES=1: degenerates to a registered full WIDTH-bit adder with latency 1.

Test Plan:
- Reset/idle: rst_n_i=0 asserted asynchronously mid-cycle -> valid_o=0, sum_o=0, cout_o=0, ovf_o=0 immediately; ready_o=1 after release.
- Full carry chain: A=0xFFFF, B=0x0001, cin_i=0, sub_i=0, ready_i=1 -> 4 cycles later valid_o=1, sum_o=0x0000, cout_o=1, ovf_o=0.
- Signed overflow and carry-in: A=0x7FFF, B=0x0000, cin_i=1 -> sum_o=0x8000, cout_o=0, ovf_o=1. Then A=0x8000, B=0x8000 -> sum_o=0x0000, cout_o=1, ovf_o=1.
- Subtract: A=0x0005, B=0x0007, sub_i=1, cin_i=1 (must be ignored) -> sum_o=0xFFFE, cout_o=0, ovf_o=0. A=0x0007, B=0x0005 -> sum_o=0x0002, cout_o=1.
- Back-to-back with stall: issue 6 consecutive transactions (A=i, B=0x0100*i, i=1..6) with ready_i=1. Drop ready_i to 0 for 3 cycles once the first result is valid -> ready_o=0 and outputs frozen during the stall. All six results emerge in order, none lost or duplicated.
- Reset mid-stream: 3 transactions in flight, pulse rst_n_i low -> no stale results appear. The next transaction's result appears exactly 4 cycles after its acceptance.
